// File: rtl/cell_core_mc_pkg.sv
// Shared opcodes, operand/target indices and FSM states for cell_core_mc.
// Optional divider is enabled with CELL_CORE_DIV_EN.
package cell_core_mc_pkg;

   typedef enum logic [4:0] {
      OP_NOP   = 5'd0,
      OP_MOV   = 5'd1,
      OP_ADD   = 5'd2,
      OP_SUB   = 5'd3,
      OP_AND   = 5'd4,
      OP_OR    = 5'd5,
      OP_XOR   = 5'd6,
      OP_SHL   = 5'd7,
      OP_SHR   = 5'd8,
      OP_LDI   = 5'd9,
      OP_CMPEQ = 5'd10,
      OP_CMPLT = 5'd11,
      OP_MUL   = 5'd12,
      OP_DIV   = 5'd13
   } op_e;

   localparam int PRED_BIT = 5;

   localparam logic [5:0] IDX_ZERO     = 6'd0;
   localparam logic [5:0] IDX_MY       = 6'd1;
   localparam logic [5:0] IDX_N        = 6'd2;
   localparam logic [5:0] IDX_S        = 6'd3;
   localparam logic [5:0] IDX_W        = 6'd4;
   localparam logic [5:0] IDX_E        = 6'd5;
   localparam logic [5:0] IDX_NW       = 6'd6;
   localparam logic [5:0] IDX_NE       = 6'd7;
   localparam logic [5:0] IDX_SW       = 6'd8;
   localparam logic [5:0] IDX_SE       = 6'd9;
   localparam logic [5:0] IDX_X        = 6'd10;
   localparam logic [5:0] IDX_Y        = 6'd11;
   localparam logic [5:0] IDX_REG_BASE = 6'd16;
   localparam logic [5:0] IDX_VIDEO    = 6'd63;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   localparam int OPC_HI = 23;
   localparam int OPC_LO = 18;
   localparam int TGT_HI = 17;
   localparam int TGT_LO = 12;
   localparam int OPA_HI = 11;
   localparam int OPA_LO = 6;
   localparam int OPB_HI = 5;
   localparam int OPB_LO = 0;

endpackage

// File: rtl/cell_core_mc_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per edge.
// Divider datapath exists only when CELL_CORE_DIV_EN is defined.
module cell_core_mc_muldiv
   import cell_core_mc_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         is_div,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int CW = $clog2(W);

   md_state_e st_q, st_d;
   logic [W-1:0] r_q, q_q, d_q;
   logic [W-1:0] r_nx, q_nx, d_nx;
   logic [CW-1:0] cnt_q;
   logic last;

`ifdef CELL_CORE_DIV_EN
   logic [W:0] rem_sh, diff;
`endif

   assign last = (cnt_q == CW'(W - 1));
   assign busy = (st_q != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st_q <= ST_IDLE;
      else      st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      done = 1'b0;
      unique case (st_q)
         ST_IDLE: begin
            if (start) begin
`ifdef CELL_CORE_DIV_EN
               st_d = is_div ? ST_DIV : ST_MUL;
`else
               if (!is_div) st_d = ST_MUL;
`endif
            end
         end
         ST_MUL, ST_DIV: begin
            if (last) begin
               st_d = ST_IDLE;
               done = 1'b1;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   // r: accumulator/remainder, q: multiplier/quotient, d: multiplicand/divisor
   always_comb begin
      r_nx = r_q + (q_q[0] ? d_q : '0);
      q_nx = q_q >> 1;
      d_nx = d_q << 1;
`ifdef CELL_CORE_DIV_EN
      rem_sh = {r_q, q_q[W-1]};
      diff   = rem_sh - {1'b0, d_q};
      if (st_q == ST_DIV) begin
         r_nx = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
         q_nx = {q_q[W-2:0], ~diff[W]};
         d_nx = d_q;
      end
`endif
   end

   assign result = (st_q == ST_DIV) ? q_nx : r_nx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q   <= '0;
         q_q   <= '0;
         d_q   <= '0;
         cnt_q <= '0;
      end else if (st_q == ST_IDLE) begin
         if (start) begin
            r_q   <= '0;
            q_q   <= is_div ? a : b;
            d_q   <= is_div ? b : a;
            cnt_q <= '0;
         end
      end else begin
         r_q   <= r_nx;
         q_q   <= q_nx;
         d_q   <= d_nx;
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/cell_core_mc.sv
// Per-cell processing core: decode, register file, predicate, shadow/commit.
// Define CELL_CORE_DIV_EN to include the iterative divider.
module cell_core_mc
   import cell_core_mc_pkg::*;
#(
   parameter int X               = 0,
   parameter int Y               = 0,
   parameter int REGISTER_LENGTH = 8,
   parameter int NUM_REGS        = 8,
   parameter int NEIGHBORS       = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [23:0]                          instruction,
   input  logic                                 instr_valid,
   input  logic                                 commit,
   input  logic [NEIGHBORS*REGISTER_LENGTH-1:0] nbr,
   output logic                                 busy,
   output logic [REGISTER_LENGTH-1:0]           state,
   output logic [REGISTER_LENGTH-1:0]           next_video,
   output logic                                 video_valid,
   output logic                                 flag
);

   localparam int W  = REGISTER_LENGTH;
   localparam int SW = $clog2(W);

   logic [W-1:0] regs [NUM_REGS];
   logic [W-1:0] shadow_q, state_q, video_q;
   logic         vv_q, flag_q, pend_q;
   logic [5:0]   tgt_q;

   logic [5:0]   opf, tgt, ia, ib;
   logic [31:0]  imm;
   logic [W-1:0] opnd [64];
   logic [W-1:0] a, b;

   logic         accept, exec;
   logic         sc_we, flag_we, flag_val;
   logic [W-1:0] sc_val;
   logic         md_start, md_div, md_busy, md_done;
   logic [W-1:0] md_res;

   logic         wb_en, shadow_we, video_we, commit_do;
   logic [5:0]   wb_tgt;
   logic [W-1:0] wb_val, state_d;
   logic [NUM_REGS-1:0] reg_we;

   assign opf = instruction[OPC_HI:OPC_LO];
   assign tgt = instruction[TGT_HI:TGT_LO];
   assign ia  = instruction[OPA_HI:OPA_LO];
   assign ib  = instruction[OPB_HI:OPB_LO];
   assign imm = {20'd0, instruction[OPA_HI:OPB_LO]};

   // MY deliberately reads visible state, never shadow
   always_comb begin
      for (int i = 0; i < 64; i++) opnd[i] = '0;
      opnd[IDX_MY] = state_q;
      opnd[IDX_X]  = W'(X);
      opnd[IDX_Y]  = W'(Y);
      for (int k = 0; k < NEIGHBORS; k++)
         opnd[int'(IDX_N) + k] = nbr[k*W +: W];
      for (int k = 0; k < NUM_REGS; k++)
         opnd[int'(IDX_REG_BASE) + k] = regs[k];
   end

   assign a = opnd[ia];
   assign b = opnd[ib];

   always_comb begin
      accept   = instr_valid & ~md_busy;
      exec     = accept & (~opf[PRED_BIT] | flag_q);
      sc_we    = 1'b0;
      sc_val   = '0;
      flag_we  = 1'b0;
      flag_val = 1'b0;
      md_start = 1'b0;
      md_div   = 1'b0;
      if (exec) begin
         unique case (opf[4:0])
            OP_MOV:   begin sc_we = 1'b1; sc_val = a; end
            OP_ADD:   begin sc_we = 1'b1; sc_val = a + b; end
            OP_SUB:   begin sc_we = 1'b1; sc_val = a - b; end
            OP_AND:   begin sc_we = 1'b1; sc_val = a & b; end
            OP_OR:    begin sc_we = 1'b1; sc_val = a | b; end
            OP_XOR:   begin sc_we = 1'b1; sc_val = a ^ b; end
            OP_SHL:   begin sc_we = 1'b1; sc_val = a << b[SW-1:0]; end
            OP_SHR:   begin sc_we = 1'b1; sc_val = a >> b[SW-1:0]; end
            OP_LDI:   begin sc_we = 1'b1; sc_val = imm[W-1:0]; end
            OP_CMPEQ: begin flag_we = 1'b1; flag_val = (a == b); end
            OP_CMPLT: begin flag_we = 1'b1; flag_val = (a < b); end
            OP_MUL:   md_start = 1'b1;
            OP_DIV: begin
`ifdef CELL_CORE_DIV_EN
               md_start = 1'b1;
               md_div   = 1'b1;
`endif
            end
            default: ;
         endcase
      end
   end

   cell_core_mc_muldiv #(
      .W (W)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .is_div (md_div),
      .a      (a),
      .b      (b),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_res)
   );

   // Single-cycle and multi-cycle writes never share an edge
   always_comb begin
      wb_en     = sc_we | md_done;
      wb_tgt    = md_done ? tgt_q : tgt;
      wb_val    = md_done ? md_res : sc_val;
      shadow_we = wb_en & (wb_tgt == IDX_MY);
      video_we  = wb_en & (wb_tgt == IDX_VIDEO);
      for (int k = 0; k < NUM_REGS; k++)
         reg_we[k] = wb_en & (wb_tgt == IDX_REG_BASE + 6'(k));
      commit_do = (commit & ~md_busy) | (md_done & (pend_q | commit));
      state_d   = (md_done & shadow_we) ? wb_val : shadow_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
         shadow_q <= '0;
         state_q  <= '0;
         video_q  <= '0;
         vv_q     <= 1'b0;
         flag_q   <= 1'b0;
         pend_q   <= 1'b0;
         tgt_q    <= '0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++)
            if (reg_we[k]) regs[k] <= wb_val;
         if (shadow_we) shadow_q <= wb_val;
         if (commit_do) state_q <= state_d;
         if (video_we) video_q <= wb_val;
         vv_q <= video_we;
         if (flag_we) flag_q <= flag_val;
         if (md_done) pend_q <= 1'b0;
         else if (commit & md_busy) pend_q <= 1'b1;
         if (md_start) tgt_q <= tgt;
      end
   end

   assign busy        = md_busy;
   assign state       = state_q;
   assign next_video  = video_q;
   assign video_valid = vv_q;
   assign flag        = flag_q;

endmodule

// File: tb/tb_cell_core_mc.sv
// Directed bench for cell_core_mc (W=8, Moore neighbourhood, X=3, Y=5).
// Divider checks follow CELL_CORE_DIV_EN.
module tb_cell_core_mc;

   localparam int W  = 8;
   localparam int NB = 8;

   localparam logic [5:0] R0 = 6'd16, R1 = 6'd17, R2 = 6'd18, R3 = 6'd19;
   localparam logic [5:0] MY = 6'd1, VID = 6'd63;
   localparam logic [5:0] MOV = 6'd1, ADD = 6'd2, SUB = 6'd3, SHL = 6'd7;
   localparam logic [5:0] SHR = 6'd8, CEQ = 6'd10, CLT = 6'd11;
   localparam logic [5:0] MUL = 6'd12, DIV = 6'd13;
   localparam logic [5:0] PMOV = 6'h21, PMUL = 6'h2C;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [23:0]   instruction = '0;
   logic          instr_valid = 1'b0;
   logic          commit = 1'b0;
   logic [NB*W-1:0] nbr = '0;
   logic          busy;
   logic [W-1:0]  state, next_video;
   logic          video_valid, flag;

   int checks = 0;
   int errors = 0;
   int n;

   cell_core_mc #(
      .X (3), .Y (5), .REGISTER_LENGTH (W), .NUM_REGS (8), .NEIGHBORS (NB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .commit      (commit),
      .nbr         (nbr),
      .busy        (busy),
      .state       (state),
      .next_video  (next_video),
      .video_valid (video_valid),
      .flag        (flag)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] ins(input logic [5:0] op, t, x, y);
      return {op, t, x, y};
   endfunction

   function automatic logic [23:0] ldi(input logic [5:0] t,
                                       input logic [11:0] v);
      return {6'd9, t, v};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [23:0] i, input logic v, input logic c);
      instruction = i;
      instr_valid = v;
      commit      = c;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      commit      = 1'b0;
   endtask

   task automatic go(input logic [23:0] i);
      cyc(i, 1'b1, 1'b0);
   endtask

   task automatic show(input string tag, input logic [5:0] src,
                       input logic [7:0] exp);
      go(ins(MOV, VID, src, 6'd0));
      chk(tag, 32'(next_video), 32'(exp));
      chk({tag, "_vv"}, 32'(video_valid), 32'd1);
   endtask

   initial begin
      nbr = {8'hA8, 8'hA7, 8'hA6, 8'h11, 8'hA4, 8'hA3, 8'hA2, 8'hA1};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_video", 32'(next_video), 32'd0);
      chk("rst_vv", 32'(video_valid), 32'd0);
      chk("rst_flag", 32'(flag), 32'd0);
      rst = 1'b1;
      cyc('0, 1'b0, 1'b0);

      go(ldi(R0, 12'd200));
      go(ldi(R1, 12'd100));
      go(ins(ADD, R2, R0, R1));
      show("add", R2, 8'd44);
      cyc('0, 1'b0, 1'b0);
      chk("vv_pulse", 32'(video_valid), 32'd0);
      go(ins(SUB, R3, R1, R0));
      show("sub", R3, 8'd156);

      go(ldi(R0, 12'd13));
      go(ldi(R1, 12'd21));
      go(ins(MUL, R2, R0, R1));
      chk("mul_busy", 32'(busy), 32'd1);
      n = 0;
      while (busy && n < 20) begin
         n++;
         go(ldi(R2, 12'd99));
      end
      chk("mul_cycles", 32'(n), 32'd8);
      show("mul", R2, 8'd17);

`ifdef CELL_CORE_DIV_EN
      go(ldi(R0, 12'd200));
      go(ldi(R1, 12'd7));
      go(ins(DIV, R2, R0, R1));
      n = 0;
      while (busy && n < 20) begin
         n++;
         cyc('0, 1'b0, 1'b0);
      end
      chk("div_cycles", 32'(n), 32'd8);
      show("div", R2, 8'd28);
      go(ldi(R1, 12'd0));
      go(ins(DIV, R3, R0, R1));
      n = 0;
      while (busy && n < 20) begin
         n++;
         cyc('0, 1'b0, 1'b0);
      end
      show("div0", R3, 8'hFF);
`else
      go(ins(DIV, R2, R0, R1));
      chk("div_nobusy", 32'(busy), 32'd0);
      show("div_nop", R2, 8'd17);
`endif

      go(ldi(R0, 12'd5));
      go(ldi(R1, 12'd5));
      go(ins(CEQ, 6'd0, R0, R1));
      chk("cmpeq", 32'(flag), 32'd1);
      go(ins(PMOV, R2, 6'd10, 6'd0));
      show("pmov_x", R2, 8'd3);
      go(ldi(R0, 12'd9));
      go(ldi(R1, 12'd3));
      go(ins(CLT, R3, R0, R1));
      chk("cmplt", 32'(flag), 32'd0);
      go(ins(PMUL, R2, R0, R1));
      chk("pmul_busy", 32'(busy), 32'd0);
      go(ins(PMOV, VID, 6'd11, 6'd0));
      chk("pmov_vv", 32'(video_valid), 32'd0);
      show("pmul_r2", R2, 8'd3);

      go(ldi(R0, 12'h0F0));
      go(ldi(R1, 12'd11));
      go(ins(SHL, R2, R0, R1));
      go(ins(SHR, R3, R0, R1));
      show("shl", R2, 8'h80);
      show("shr", R3, 8'h1E);

      go(ins(MOV, MY, 6'd6, 6'd0));
      chk("shadow_hidden", 32'(state), 32'd0);
      cyc(ldi(MY, 12'h022), 1'b1, 1'b1);
      chk("same_edge", 32'(state), 32'h11);
      cyc('0, 1'b0, 1'b1);
      chk("commit2", 32'(state), 32'h22);
      go(ldi(MY, 12'h033));
      show("my_visible", MY, 8'h22);

      go(ldi(R0, 12'd12));
      go(ldi(R1, 12'd11));
      go(ins(MUL, MY, R0, R1));
      cyc('0, 1'b0, 1'b1);
      n = 1;
      while (busy && n < 20) begin
         chk("pend_hold", 32'(state), 32'h22);
         n++;
         cyc('0, 1'b0, 1'b0);
      end
      chk("pend_cycles", 32'(n), 32'd8);
      chk("pend_commit", 32'(state), 32'h84);

      show("video_y", 6'd11, 8'd5);
      cyc('0, 1'b0, 1'b0);
      chk("video_y_pulse", 32'(video_valid), 32'd0);
      show("nbr_s", 6'd3, 8'hA2);
      show("idx12", 6'd12, 8'd0);

      go(ins(CEQ, 6'd0, 6'd0, 6'd0));
      chk("flag_set", 32'(flag), 32'd1);
`ifdef CELL_CORE_DIV_EN
      go(ins(DIV, R2, R0, R1));
`else
      go(ins(MUL, R2, R0, R1));
`endif
      cyc('0, 1'b0, 1'b0);
      cyc('0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_video", 32'(next_video), 32'd0);
      chk("arst_vv", 32'(video_valid), 32'd0);
      chk("arst_flag", 32'(flag), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (10) cyc('0, 1'b0, 1'b0);
      chk("arst_idle", 32'(busy), 32'd0);
      chk("arst_state2", 32'(state), 32'd0);
      show("arst_r2", R2, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cell_core_mc.md
Name: cell_core_mc

Overview:
Next-generation per-cell processing core for the cellular-automaton array. Generalises the current cell core in register width, register-file depth and neighbourhood (von Neumann or Moore). Adds predicated execution, a double-buffered cell state with a grid-wide commit, and multi-cycle MUL/DIV with a busy stall. One instance per grid cell; the global sequencer broadcasts instructions and ANDs/ORs per-cell busy.

Parameters:
X, 0, cell column, readable as an operand constant
Y, 0, cell row, readable as an operand constant
REGISTER_LENGTH, 8, datapath width W (4..32)
NUM_REGS, 8, general registers R0..R(NUM_REGS-1) (1..47)
NEIGHBORS, 4, 4 = N,S,W,E; 8 = adds NW,NE,SW,SE

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
instruction  in  24  broadcast instruction: [23:18] opcode, [17:12] target, [11:6] opA, [5:0] opB
instr_valid  in  1  instruction present this cycle
commit  in  1  grid-wide copy of shadow state to visible state
nbr  in  NEIGHBORS*W  neighbour states, LSB first: N,S,W,E,NW,NE,SW,SE
busy  out  1  multi-cycle op in flight; sequencer stalls
state  out  W  visible cell state (feeds neighbours)
next_video  out  W  last value written to VIDEO
video_valid  out  1  one-cycle pulse when next_video updates
flag  out  1  predicate flag

Behaviour:
- Reset (rst=0, async): all registers, shadow, state, next_video, flag = 0; video_valid=0, busy=0; an in-flight MUL/DIV is aborted with no write.
- Operand index: 0 ZERO, 1 MY (visible state), 2-9 neighbours in nbr order (6-9 read 0 when NEIGHBORS=4), 10 X, 11 Y, 12-15 read 0, 16+k Rk (k >= NUM_REGS reads 0).
- Target index: 1 = shadow state, 16+k = Rk, 63 = VIDEO; any other target = write discarded.
- Opcode bit5 = predicated: if set and flag=0, instruction is a NOP (no writes, no MUL/DIV start).
- Opcode[4:0]: 0 NOP, 1 MOV(A), 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 SHL, 8 SHR, 9 LDI (instruction[11:0] zero-extended/truncated to W), 10 CMPEQ, 11 CMPLT (unsigned; writes flag only, target ignored), 12 MUL, 13 DIV; 14-31 NOP.
- Arithmetic is modulo 2^W. Shift amount = B mod W (low clog2(W) bits). MUL = low W bits of the unsigned product. DIV = unsigned quotient; B=0 gives all-ones.
- Accept: the instruction is taken on a rising edge with instr_valid=1 and busy=0. While busy=1, instr_valid is ignored.
- Single-cycle ops write at the accept edge.
- FSM IDLE -> MUL or DIV on accept of an executing MUL/DIV. Operands and target are latched. busy=1 for exactly W cycles (one iteration per edge). The result is written at the W-th edge, then the FSM returns to IDLE and busy=0.
- VIDEO write: next_video updated; video_valid=1 for the following cycle only.
- Commit: on an edge with commit=1 and busy=0, state <= shadow.
  - commit while busy=1 sets a pending bit. The commit is performed on the edge where the multi-cycle write completes, so the new result is included.
  - A second commit while pending is merged.
- Same-edge commit and shadow write: state takes the old shadow; shadow takes the new value.
- MY always reads visible state, never shadow.

Optional Feature:
CELL_CORE_DIV_EN
- Defined: DIV as above, via the shared iterative unit.
- Undefined: no divider hardware. Opcode 13 is a single-cycle NOP, busy is never raised for it, and the restoring-divide datapath is removed.

Decomposition:
- Package cell_core_mc_pkg: opcode enum (5-bit op plus predicate bit position), operand/target index constants (ZERO, MY, N..SE, X, Y, REG_BASE=16, VIDEO=63), FSM state enum {IDLE, MUL, DIV}, instruction field slice constants.
- Sub-module cell_core_mc_muldiv: iterative shift-add multiplier / restoring divider with start/done and its own W-cycle counter. The core keeps decode, register file, predicate, commit logic.

Test Plan:
- W=8, NEIGHBORS=4: LDI R0,200; LDI R1,100; ADD R2,R0,R1 -> R2=44; SUB R3,R1,R0 -> R3=156.
- MUL R2,R0(13),R1(21) -> busy high exactly 8 cycles, R2=17 (273 mod 256), instr_valid ignored during busy; DIV 200/7 -> 28; DIV by 0 -> 255 (with CELL_CORE_DIV_EN).
- CMPEQ R0(5),R1(5) -> flag=1; predicated MOV R2 <- X executes; CMPLT 9,3 -> flag=0; predicated MUL -> no busy, R2 unchanged.
- NEIGHBORS=8, nbr NW=0x11: MOV MY,NW -> state stays 0 until commit pulse, then state=0x11; same-edge MOV MY,0x22 plus commit -> state=0x11, shadow=0x22.
- commit asserted mid-MUL targeting MY -> state updates on the MUL completion edge with the product; MOV VIDEO,Y -> next_video=Y, video_valid for one cycle.
- rst low in cycle 3 of a DIV -> busy=0, all outputs 0, no write after rst release.
